// File: rtl/chip8_timer_pkg.sv
// Shared constants and width helpers for the CHIP-8 timebase.
// Timer index constants let the CPU side name the delay and sound timers.
package chip8_timer_pkg;

  localparam int DEFAULT_CLK_HZ  = 50_000_000;
  localparam int DEFAULT_TICK_HZ = 60;

  localparam int TIMER_DELAY = 0;
  localparam int TIMER_SOUND = 1;

  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counter and select widths never collapse to zero bits.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int sel_width(input int num_timers);
    return width_of(num_timers);
  endfunction

endpackage

// File: rtl/chip8_countdown.sv
// One saturating down-counter: a load wins over a decrement, and the
// counter sticks at zero instead of wrapping.
module chip8_countdown #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_data,
  input  logic               dec,
  output logic [TIMER_W-1:0] value,
  output logic               nonzero
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: the hold value is assigned first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_data;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignment so all flops update from pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign value   = count_q;
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/chip8_timer_unit.sv
// CHIP-8 timebase: 60 Hz tick prescaler, CPU-loadable countdown timers,
// renderer frame strobe and heartbeat LED.
module chip8_timer_unit
  import chip8_timer_pkg::*;
#(
  parameter int CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int TICK_HZ         = DEFAULT_TICK_HZ,
  parameter int NUM_TIMERS      = 2,
  parameter int TIMER_W         = 8,
  parameter int FRAME_DIV       = 1,
  parameter int HEARTBEAT_TICKS = 30,
  localparam int SEL_W          = sel_width(NUM_TIMERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_en,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [TIMER_W-1:0]    wr_data,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [TIMER_W-1:0]    rd_data,
  output logic [NUM_TIMERS-1:0] timer_active,
  output logic                  tick,
  output logic                  frame_start,
  output logic                  led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = width_of(DIV);
  localparam int FW  = width_of(FRAME_DIV);
  localparam int HW  = width_of(HEARTBEAT_TICKS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [HW-1:0] HB_LAST    = HW'(HEARTBEAT_TICKS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("chip8_timer_unit: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (NUM_TIMERS < 1 || FRAME_DIV < 1 || HEARTBEAT_TICKS < 1) begin : g_bad_count
    $error("chip8_timer_unit: NUM_TIMERS, FRAME_DIV and HEARTBEAT_TICKS must be >= 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] hb_q, hb_d;
  logic          tick_q, tick_d;
  logic          frame_q, frame_d;
  logic          led_q, led_d;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (tick_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Frame and heartbeat counters advance on the registered tick, so their
  // outputs land one cycle after the tick pulse.
  always_comb begin
    fcnt_d  = fcnt_q;
    frame_d = 1'b0;
    hb_d    = hb_q;
    led_d   = led_q;
    if (tick_q) begin
      if (fcnt_q == FRAME_LAST) begin
        fcnt_d  = '0;
        frame_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
      if (hb_q == HB_LAST) begin
        hb_d  = '0;
        led_d = ~led_q;
      end else begin
        hb_d = hb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
      frame_q <= 1'b0;
      hb_q    <= '0;
      led_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
      frame_q <= frame_d;
      hb_q    <= hb_d;
      led_q   <= led_d;
    end
  end

  logic [TIMER_W-1:0]    timer_val [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] timer_load;

  // Out-of-range wr_sel values match no index, so such writes fall away.
  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    assign timer_load[i] = wr_en && (wr_sel == SEL_W'(i));

    chip8_countdown #(
      .TIMER_W (TIMER_W)
    ) u_countdown (
      .clk       (clk),
      .reset     (reset),
      .load      (timer_load[i]),
      .load_data (wr_data),
      .dec       (tick_q),
      .value     (timer_val[i]),
      .nonzero   (timer_active[i])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data = timer_val[i];
    end
  end

  assign tick        = tick_q;
  assign frame_start = frame_q;
  assign led         = led_q;

endmodule

// File: tb/tb_chip8_timer_unit.sv
// Self-checking bench for chip8_timer_unit: register-port table, directed
// timing sequences, then randomized traffic against a count-based model.
module tb_chip8_timer_unit;
  import chip8_timer_pkg::*;

  localparam int NT  = 3;
  localparam int DIV = 10;
  localparam int FD  = 2;
  localparam int HB  = 3;

  logic       clk = 1'b0;
  logic       reset, tick_en, wr_en;
  logic [1:0] wr_sel, rd_sel;
  logic [7:0] wr_data, rd_data;
  logic [2:0] timer_active;
  logic       tick, frame_start, led;

  chip8_timer_unit #(
    .CLK_HZ          (600),
    .TICK_HZ         (60),
    .NUM_TIMERS      (NT),
    .TIMER_W         (8),
    .FRAME_DIV       (FD),
    .HEARTBEAT_TICKS (HB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_en      (tick_en),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data),
    .timer_active (timer_active),
    .tick         (tick),
    .frame_start  (frame_start),
    .led          (led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tick and strobes follow from counts of enabled edges
  // and consumed ticks since reset; timers are plain integers.
  int m_en_edges, m_ticks;
  bit m_tick, m_frame, m_led;
  int m_timer [NT];

  task automatic model_edge();
    bit old_tick;
    if (reset) begin
      m_en_edges = 0; m_ticks = 0;
      m_tick = 0; m_frame = 0; m_led = 0;
      for (int i = 0; i < NT; i++) m_timer[i] = 0;
    end else begin
      old_tick = m_tick;
      for (int i = 0; i < NT; i++) begin
        if (wr_en && int'(wr_sel) == i) m_timer[i] = int'(wr_data);
        else if (old_tick && m_timer[i] > 0) m_timer[i] = m_timer[i] - 1;
      end
      m_frame = 0;
      if (old_tick) begin
        m_ticks++;
        m_frame = (m_ticks % FD) == 0;
        m_led   = ((m_ticks / HB) % 2) == 1;
      end
      if (tick_en) begin
        m_en_edges++;
        m_tick = (m_en_edges % DIV) == 0;
      end else begin
        m_tick = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [2:0] exp_act;
    int exp_rd;
    for (int i = 0; i < NT; i++) exp_act[i] = (m_timer[i] != 0);
    exp_rd = (int'(rd_sel) < NT) ? m_timer[rd_sel] : 0;
    check("rand tick", tick, m_tick);
    check("rand frame_start", frame_start, m_frame);
    check("rand led", led, m_led);
    check("rand rd_data", rd_data, exp_rd);
    check("rand timer_active", timer_active, exp_act);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1; tick_en = 0; wr_en = 0; wr_sel = 0; wr_data = 0; rd_sel = 0;
    cycle();
    reset = 0;
  endtask

  typedef struct {
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic [1:0] rd_sel;
    logic [7:0] exp_rd;
    logic [2:0] exp_active;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 2'd0, 8'h12, 2'd0, 8'h12, 3'b001};
    vecs[1] = '{1'b1, 2'd1, 8'hA5, 2'd1, 8'hA5, 3'b011};
    vecs[2] = '{1'b1, 2'd2, 8'h01, 2'd2, 8'h01, 3'b111};
    vecs[3] = '{1'b1, 2'd3, 8'hFF, 2'd3, 8'h00, 3'b111};
    vecs[4] = '{1'b0, 2'd0, 8'h77, 2'd0, 8'h12, 3'b111};
    vecs[5] = '{1'b1, 2'd1, 8'h00, 2'd1, 8'h00, 3'b101};
    vecs[6] = '{1'b1, 2'd0, 8'h00, 2'd2, 8'h01, 3'b100};
    vecs[7] = '{1'b0, 2'd3, 8'h00, 2'd3, 8'h00, 3'b100};
    vecs[8] = '{1'b1, 2'd2, 8'h80, 2'd2, 8'h80, 3'b100};

    reset = 1; tick_en = 0; wr_en = 0; wr_sel = 0; wr_data = 0; rd_sel = 0;
    run(2);
    check("reset tick", tick, 0);
    check("reset frame_start", frame_start, 0);
    check("reset led", led, 0);
    check("reset rd_data", rd_data, 0);
    check("reset timer_active", timer_active, 0);

    // Register port with the timebase frozen: no decrements interfere.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel;
      wr_data = vecs[i].wr_data; rd_sel = vecs[i].rd_sel;
      cycle();
      wr_en = 0;
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d timer_active", i), timer_active, vecs[i].exp_active);
      check($sformatf("vec%0d tick", i), tick, 0);
    end

    // Tick cadence, frame strobe every 2nd tick, led toggling every 3rd.
    do_reset();
    tick_en = 1;
    for (int e = 1; e <= 75; e++) begin
      cycle();
      check($sformatf("cadence tick e%0d", e), tick, (e % 10) == 0);
      check($sformatf("cadence frame e%0d", e), frame_start, (e > 1) && ((e % 20) == 1));
      check($sformatf("cadence led e%0d", e), led, (e >= 31) && (e <= 60));
    end

    // Delay timer counts down on ticks and saturates at zero.
    do_reset();
    tick_en = 1;
    wr_en = 1; wr_sel = 2'(TIMER_DELAY); wr_data = 8'd3; rd_sel = 2'(TIMER_DELAY);
    cycle();
    wr_en = 0;
    check("delay load", rd_data, 3);
    check("delay active", timer_active[0], 1);
    run(9);
    check("delay tick pending", tick, 1);
    check("delay before tick1", rd_data, 3);
    cycle();
    check("delay after tick1", rd_data, 2);
    run(10);
    check("delay after tick2", rd_data, 1);
    run(10);
    check("delay after tick3", rd_data, 0);
    check("delay inactive", timer_active[0], 0);
    run(10);
    check("delay saturates", rd_data, 0);

    // A write landing with a tick loads the exact value.
    run(9);
    check("sound tick high", tick, 1);
    wr_en = 1; wr_sel = 2'(TIMER_SOUND); wr_data = 8'd5; rd_sel = 2'(TIMER_SOUND);
    cycle();
    wr_en = 0;
    check("sound load wins", rd_data, 5);
    run(9);
    check("sound held", rd_data, 5);
    cycle();
    check("sound after tick", rd_data, 4);

    // tick_en freeze at presc = 4 for 25 cycles.
    do_reset();
    tick_en = 1;
    run(4);
    tick_en = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      check($sformatf("frozen tick c%0d", i), tick, 0);
    end
    tick_en = 1;
    run(5);
    check("resume tick early", tick, 0);
    cycle();
    check("resume tick 6th edge", tick, 1);

    // Reset at presc = 9 suppresses the pending tick.
    do_reset();
    tick_en = 1;
    wr_en = 1; wr_sel = 2'(TIMER_DELAY); wr_data = 8'd200; rd_sel = 0;
    cycle();
    wr_en = 0;
    check("pre-reset load", rd_data, 200);
    run(8);
    reset = 1;
    cycle();
    reset = 0;
    check("rst tick suppressed", tick, 0);
    check("rst rd_data", rd_data, 0);
    check("rst timer_active", timer_active, 0);
    check("rst frame_start", frame_start, 0);
    check("rst led", led, 0);
    run(9);
    check("post-rst no early tick", tick, 0);
    cycle();
    check("post-rst tick", tick, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      tick_en = ($urandom_range(0, 7) != 0);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_sel  = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      rd_sel  = 2'($urandom_range(0, 3));
      cycle();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
